// File: rtl/scope_pkg.sv
// Shared constants and types for the oscilloscope trace renderer:
// default timing, 4-bit-per-channel colours and the capture-state encoding.
package scope_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Colours packed as {red, green, blue}, 4 bits each
    localparam logic [11:0] C_TRACE = 12'h0F0;
    localparam logic [11:0] C_GRID  = 12'h444;
    localparam logic [11:0] C_BLACK = 12'h000;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/scope_sample_ram.sv
// Double-buffered sample store: two banks of H_ACTIVE samples, one write
// port for the capture side and one registered read port for the renderer.
module scope_sample_ram #(
    parameter int SAMPLE_W = 8,
    parameter int H_ACTIVE = 640,
    parameter int ADDR_W   = 10
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic                i_wr_bank,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    input  logic                i_rd_bank,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data
);

    logic [SAMPLE_W-1:0] mem_q [2][H_ACTIVE];
    logic [SAMPLE_W-1:0] rd_data_d;
    logic [SAMPLE_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem_q[i_rd_bank][i_rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/scope_trace_renderer.sv
// Triggered single-sweep capture into a double-buffered RAM plus a 2-stage
// pixel pipeline drawing a filled trace over a graticule behind VGA timing.
module scope_trace_renderer #(
    parameter int SAMPLE_W   = 8,
    parameter int H_ACTIVE   = scope_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = scope_pkg::V_ACTIVE,
    parameter int V_OFFSET   = 112,
    parameter int GRID_SHIFT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_trig_en,
    input  logic [SAMPLE_W-1:0] i_trig_level,
    input  logic [9:0]          i_coord_x,
    input  logic [9:0]          i_coord_y,
    input  logic                i_active,
    input  logic                i_h_sync,
    input  logic                i_v_sync,
    output logic [3:0]          o_red,
    output logic [3:0]          o_green,
    output logic [3:0]          o_blue,
    output logic                o_h_sync,
    output logic                o_v_sync,
    output logic                o_armed,
    output logic                o_frame_swap
);

    import scope_pkg::*;

    localparam int              PTR_W      = $clog2(H_ACTIVE);
    localparam int              S_MAX      = (1 << SAMPLE_W) - 1;
    localparam int              S_HALF     = 1 << (SAMPLE_W - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(H_ACTIVE - 1);
    localparam logic [9:0]      FRAME_ROW  = 10'(V_ACTIVE);
    localparam logic [9:0]      CENTRE_ROW = 10'(V_OFFSET + S_HALF);
    localparam logic [9:0]      H_LIMIT    = 10'(H_ACTIVE);

    // Screen row of a sample: full scale sits at V_OFFSET, zero at the bottom
    function automatic logic [9:0] row_of(input logic [SAMPLE_W-1:0] s);
        return 10'(V_OFFSET) + 10'(S_MAX) - 10'(s);
    endfunction

    cap_state_t            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [SAMPLE_W-1:0]   prev_sample_q, prev_sample_d;
    logic                  disp_bank_q, disp_bank_d;
    logic                  frame_swap_q, frame_swap_d;
    logic                  shown_q, shown_d;
    logic                  frame_end;
    logic                  trig_hit;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [PTR_W-1:0]      rd_addr;
    logic [SAMPLE_W-1:0]   rd_data;

    assign frame_end = (i_coord_y == FRAME_ROW) && (i_coord_x == 10'd0);
    assign trig_hit  = !i_trig_en ||
                       ((prev_sample_q < i_trig_level) && (i_sample >= i_trig_level));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED:   if (i_sample_valid && trig_hit) state_d = CAPTURE;
            CAPTURE: if (i_sample_valid && (ptr_q == LAST_PTR)) state_d = DONE;
            DONE:    if (frame_end) state_d = ARMED;
            default: state_d = ARMED;
        endcase
    end

    // A swap happens only from DONE, so a partial sweep never reaches the screen
    always_comb begin
        wr_en         = 1'b0;
        wr_addr       = ptr_q;
        ptr_d         = ptr_q;
        disp_bank_d   = disp_bank_q;
        frame_swap_d  = 1'b0;
        shown_d       = shown_q;
        prev_sample_d = i_sample_valid ? i_sample : prev_sample_q;
        o_armed       = (state_q == ARMED);
        unique case (state_q)
            ARMED: begin
                if (i_sample_valid && trig_hit) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    ptr_d   = PTR_W'(1);
                end
            end
            CAPTURE: begin
                if (i_sample_valid) begin
                    wr_en = 1'b1;
                    ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
                end
            end
            DONE: begin
                if (frame_end) begin
                    disp_bank_d  = ~disp_bank_q;
                    frame_swap_d = 1'b1;
                    shown_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // shown_q keeps uninitialised RAM off screen until a full sweep has been swapped in
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q         <= '0;
            prev_sample_q <= '0;
            disp_bank_q   <= 1'b0;
            frame_swap_q  <= 1'b0;
            shown_q       <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            prev_sample_q <= prev_sample_d;
            disp_bank_q   <= disp_bank_d;
            frame_swap_q  <= frame_swap_d;
            shown_q       <= shown_d;
        end
    end

    assign o_frame_swap = frame_swap_q;
    assign rd_addr      = (i_coord_x < H_LIMIT) ? i_coord_x[PTR_W-1:0] : '0;

    scope_sample_ram #(
        .SAMPLE_W (SAMPLE_W),
        .H_ACTIVE (H_ACTIVE),
        .ADDR_W   (PTR_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_en),
        .i_wr_bank (~disp_bank_q),
        .i_wr_addr (wr_addr),
        .i_wr_data (i_sample),
        .i_rd_bank (disp_bank_q),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    logic [9:0]          x_p1_q, x_p1_d;
    logic [9:0]          y_p1_q, y_p1_d;
    logic                active_p1_q, active_p1_d;
    logic                hs_p1_q, hs_p1_d;
    logic                vs_p1_q, vs_p1_d;
    logic [SAMPLE_W-1:0] prev_col_q, prev_col_d;
    logic [11:0]         rgb_p2_q, rgb_p2_d;
    logic                hs_p2_q, hs_p2_d;
    logic                vs_p2_q, vs_p2_d;
    logic [9:0]          y_t, y_p, y_lo, y_hi;
    logic                is_trace, is_grid;

    // Stage 1: RAM read in flight, coordinates and syncs delayed alongside
    always_comb begin
        x_p1_d      = i_coord_x;
        y_p1_d      = i_coord_y;
        active_p1_d = i_active;
        hs_p1_d     = i_h_sync;
        vs_p1_d     = i_v_sync;
    end

    always_ff @(posedge i_clk) begin
        x_p1_q     <= x_p1_d;
        y_p1_q     <= y_p1_d;
        prev_col_q <= prev_col_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_p1_q <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
        end else begin
            active_p1_q <= active_p1_d;
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
        end
    end

    // Stage 2: span between this column's row and the previous column's row
    always_comb begin
        prev_col_d = rd_data;
        y_t        = row_of(rd_data);
        y_p        = (x_p1_q == 10'd0) ? y_t : row_of(prev_col_q);
        y_lo       = (y_t < y_p) ? y_t : y_p;
        y_hi       = (y_t < y_p) ? y_p : y_t;
        is_trace   = shown_q && (y_p1_q >= y_lo) && (y_p1_q <= y_hi);
        is_grid    = (x_p1_q[GRID_SHIFT-1:0] == '0) ||
                     (y_p1_q[GRID_SHIFT-1:0] == '0) ||
                     (y_p1_q == CENTRE_ROW);
        if (!active_p1_q) begin
            rgb_p2_d = C_BLACK;
        end else if (is_trace) begin
            rgb_p2_d = C_TRACE;
        end else if (is_grid) begin
            rgb_p2_d = C_GRID;
        end else begin
            rgb_p2_d = C_BLACK;
        end
        hs_p2_d = hs_p1_q;
        vs_p2_d = vs_p1_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_p2_q <= C_BLACK;
            hs_p2_q  <= 1'b1;
            vs_p2_q  <= 1'b1;
        end else begin
            rgb_p2_q <= rgb_p2_d;
            hs_p2_q  <= hs_p2_d;
            vs_p2_q  <= vs_p2_d;
        end
    end

    assign o_red    = rgb_p2_q[11:8];
    assign o_green  = rgb_p2_q[7:4];
    assign o_blue   = rgb_p2_q[3:0];
    assign o_h_sync = hs_p2_q;
    assign o_v_sync = vs_p2_q;

endmodule
